complex_mul_iq: RTL and testbench
=================================

# complex_mul_iq

Parametrised flow-through complex multiplier for time-interleaved I/Q streams. It is the next-generation replacement for the fixed 18-bit interleaved vector multiplier. It adds the following over that block:
- configurable width and output scaling;
- a per-pair conjugate mode;
- pair-framing checks;
- sticky overflow and framing flags.

It sits in the LLRF signal path between the downconversion/CIC stages and the feedback and rotation logic.

## Interface
Parameters:
- DW, 18, sample width of x, y and z (signed, 8..25)
- SHIFT, DW-1, right shift applied to the full sum before saturation (0..DW)

Ports:
- clk  in  1  rising-edge clock; all logic synchronous to it
- rst_n  in  1  reset, synchronous, active-low
- gate_in  in  1  input sample valid
- iq  in  1  high = I sample, low = Q sample; a pair is I followed by Q on the next cycle
- conj  in  1  sampled with the I sample; high computes x·conj(y) for that pair
- x  in  DW  signed multiplicand, interleaved I/Q
- y  in  DW  signed multiplicand, interleaved I/Q
- clr_flags  in  1  clears ovf and pair_err
- z  out  DW  scaled, saturated result, interleaved I/Q
- z_full  out  2*DW+1  unscaled full-precision sum, aligned with z
- iq_out  out  1  iq aligned with z
- gate_out  out  1  valid aligned with z; low for rejected slots
- ovf  out  1  sticky: set when any output saturated
- pair_err  out  1  sticky: set on a framing violation

## Operation
- A valid pair is an I sample and a Q sample on consecutive cycles:
  - I sample: gate_in=1, iq=1 at cycle t.
  - Q sample: gate_in=1, iq=0 at cycle t+1.
- Framing violations; each sets pair_err, and the affected slot(s) propagate with gate_out=0:
  - an I sample not followed by a valid Q sample (gate drop, or a second I);
  - a Q sample with no pending I.
- A second I sample that broke the previous pair starts a new pair.
- Normal arithmetic, full precision, width 2*DW+1:
  - zr = xr·yr − xi·yi
  - zi = xr·yi + xi·yr
- With conj=1:
  - zr = xr·yr + xi·yi
  - zi = xi·yr − xr·yi
- conj is registered with the I sample and held for the Q sample of the same pair.
- Scaling: z = SAT_DW(S >>> SHIFT), where >>> is an arithmetic shift.
- Saturation clamps to +2^(DW-1)−1 or −2^(DW-1). Any clamp on a slot with gate_out=1 sets ovf on the same cycle.
- The full-scale negative × full-scale negative case is legal. It saturates; no input restriction applies.
- Flag precedence: flag set and clr_flags asserted on the same cycle → the flag ends the cycle set.
- gate_in=0 slots still advance the pipeline. Their z, z_full and iq_out are don't-care, with gate_out=0.

## Timing
- Latency LAT = 5 cycles for every sample. An I sample at t produces its z output at t+5; the matching Q sample produces its output at t+6.
- gate_out, iq_out, z and z_full are mutually aligned and fully pipelined. One sample is accepted per cycle with no back-pressure, and back-to-back pairs are sustained indefinitely.
- pair_err asserts one cycle after the violating sample is detected (for an orphaned I, at t+2).
- ovf asserts in the same cycle as the saturated output.
- Reset (rst_n=0 at a clock edge):
  - outputs: z, z_full, iq_out, gate_out, ovf and pair_err all go to 0;
  - internal state: all pipeline state and the pending-I state are cleared.
- Reset mid-stream discards all in-flight samples. A Q sample arriving in the first cycle after reset is an orphan and flags pair_err.

## Configuration
- COMPLEX_MUL_ROUND_EN defined: 2^(SHIFT-1) is added to S before the shift (round half up). With SHIFT=0 there is no addition.
- COMPLEX_MUL_ROUND_EN undefined: truncation toward −∞ (floor). Latency is identical in both builds.

## Structure
- Package complex_mul_pkg holds:
  - localparam LAT = 5;
  - the saturating-shift function;
  - an enum for the framing state, IDLE / HAVE_I.
- One sub-module, iq_sat_shift, is natural. It owns the final pipeline stage: optional rounding, shift, saturation and the clamp indication, parametrised by input width, DW and SHIFT.
- The multiplier datapath, pairing FSM and flag logic stay in complex_mul_iq.

## Test plan
All scenarios use DW=18, SHIFT=17.
- Basic product: x=(65536,0) × y=(65536,65536).
  - z = 32768, 32768 at t+5 and t+6, with iq_out 1 then 0 and gate_out high both cycles.
- Conjugate mode: x=(0,65536), y=(0,65536).
  - conj=0 → z=(−32768,0).
  - conj=1 → z=(32768,0).
- Full-scale saturation: x=y=(−131072,−131072).
  - z_full real = 0; z_full imag = 2^35.
  - z = (0,131071), with ovf set on the Q output cycle.
  - ovf stays set until clr_flags.
- Rounding: x=(1,0), y=(65536,0) → z real 1 with COMPLEX_MUL_ROUND_EN, 0 without. x=(−1,0) gives 0 and −1 respectively.
- Framing: I, I, Q sequence with gate_in held high.
  - First slot has gate_out=0 and pair_err=1.
  - Second I plus the Q form a valid pair.
  - clr_flags clears pair_err.
- Reset mid-stream: rst_n=0 for one cycle between I and Q.
  - All outputs read 0 the next cycle.
  - No gate_out for the pre-reset I.
  - The trailing Q sets pair_err.

Source files
------------

// File: rtl/complex_mul_pkg.sv
// complex_mul_pkg: shared latency constant, pairing state and the saturating
// arithmetic shift used by the complex multiplier output stage.
package complex_mul_pkg;

    localparam int LAT = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        HAVE_I = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [63:0] val;
        logic        clamp;
    } sat_res_t;

    // Arithmetic right shift by 'shift', then clamp into a signed 'dw'-bit range.
    // Operates on a 64-bit container so it serves every legal DW.
    function automatic sat_res_t sat_shift(input logic signed [63:0] s,
                                           input int dw, input int shift);
        sat_res_t r;
        logic signed [63:0] sh, hi, lo;
        sh = s >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r.clamp = 1'b1;
        if (sh > hi)
            r.val = hi;
        else if (sh < lo)
            r.val = lo;
        else begin
            r.val   = sh;
            r.clamp = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_sat_shift.sv
// iq_sat_shift: final pipeline stage of complex_mul_iq. Optional round-half-up
// (COMPLEX_MUL_ROUND_EN), arithmetic shift, saturation to DW bits. The clamp
// indication is combinational so the parent can raise ovf with the output.
module iq_sat_shift
    import complex_mul_pkg::*;
#(
    parameter int IW    = 37,
    parameter int DW    = 18,
    parameter int SHIFT = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [IW-1:0] s_in,
    output logic                 clamp,
    output logic signed [DW-1:0] z
);

`ifdef COMPLEX_MUL_ROUND_EN
    // Half an output LSB; SHIFT=0 has no fractional part to round.
    localparam logic signed [63:0] RND =
        (SHIFT > 0) ? (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'sd0;
`endif

    logic signed [63:0]   s_ext;
    sat_res_t             sat;
    logic signed [DW-1:0] z_d, z_q;
    logic                 unused_hi;

    // Extend, optionally round, then shift and saturate.
    always_comb begin
        s_ext = {{(64-IW){s_in[IW-1]}}, s_in};
`ifdef COMPLEX_MUL_ROUND_EN
        s_ext = s_ext + RND;
`endif
        sat   = sat_shift(s_ext, DW, SHIFT);
        clamp = sat.clamp;
        z_d   = sat.val[DW-1:0];
    end

    // Upper bits are only a sign extension of the clamped result.
    assign unused_hi = ^sat.val[63:DW];

    // Output register.
    always_ff @(posedge clk) begin
        if (!rst_n) z_q <= '0;
        else        z_q <= z_d;
    end

    assign z = z_q;

endmodule

// File: rtl/complex_mul_iq.sv
// complex_mul_iq: flow-through complex multiplier for interleaved I/Q streams.
// Stages: capture -> operand select -> multiply -> sum -> scale/saturate.
// Each slot (I or Q) carries its own two products, so one result per cycle.
// Optional rounding build: define COMPLEX_MUL_ROUND_EN.
module complex_mul_iq
    import complex_mul_pkg::*;
#(
    parameter int DW    = 18,
    parameter int SHIFT = DW - 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   gate_in,
    input  logic                   iq,
    input  logic                   conj,
    input  logic signed [DW-1:0]   x,
    input  logic signed [DW-1:0]   y,
    input  logic                   clr_flags,
    output logic signed [DW-1:0]   z,
    output logic signed [2*DW:0]   z_full,
    output logic                   iq_out,
    output logic                   gate_out,
    output logic                   ovf,
    output logic                   pair_err
);

    localparam int PS = LAT - 1;  // stages after capture: op, prod, sum, out

    frame_state_e state_q, state_d;
    logic viol, sat_clamp;
    logic s1_vld_q, s1_vld_d, s1_iq_q, s1_iq_d, conj_pair_q, conj_pair_d;
    logic signed [DW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d, s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic signed [DW-1:0] a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
    logic sub_q, sub_d, sub_p_q, sub_p_d;
    logic signed [2*DW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic signed [2*DW:0] s_q, s_d, z_full_q, z_full_d;
    logic [PS-1:0] vld_pipe_q, vld_pipe_d, iq_pipe_q, iq_pipe_d;
    logic ovf_q, ovf_d, pair_err_q, pair_err_d;

    // Pairing, operand routing, arithmetic and sticky flags.
    always_comb begin
        state_d     = (gate_in && iq) ? HAVE_I : IDLE;
        // Orphan I (next slot is not a valid Q) or Q with no pending I.
        viol        = ((state_q == HAVE_I) && !(gate_in && !iq)) ||
                      ((state_q == IDLE) && gate_in && !iq);
        s1_vld_d    = gate_in && (iq || (state_q == HAVE_I));
        s1_iq_d     = iq;
        s1_x_d      = x;
        s1_y_d      = y;
        s2_x_d      = s1_x_q;
        s2_y_d      = s1_y_q;
        conj_pair_d = (gate_in && iq) ? conj : conj_pair_q;

        // I slot: xr*yr -/+ xi*yi, partner Q is on the inputs now.
        // Q slot: xi*yr +/- xr*yi, partner I sits one register back.
        if (s1_iq_q) begin
            a0_d = s1_x_q; b0_d = s1_y_q; a1_d = x;      b1_d = y;
        end else begin
            a0_d = s1_x_q; b0_d = s2_y_q; a1_d = s2_x_q; b1_d = s1_y_q;
        end
        sub_d = s1_iq_q ^ conj_pair_q;

        // An I slot only survives if its Q is arriving this cycle.
        vld_pipe_d = {vld_pipe_q[PS-2:0], s1_vld_q && (!s1_iq_q || (gate_in && !iq))};
        iq_pipe_d  = {iq_pipe_q[PS-2:0], s1_iq_q};

        p0_d    = $signed({{DW{a0_q[DW-1]}}, a0_q}) * $signed({{DW{b0_q[DW-1]}}, b0_q});
        p1_d    = $signed({{DW{a1_q[DW-1]}}, a1_q}) * $signed({{DW{b1_q[DW-1]}}, b1_q});
        sub_p_d = sub_q;

        s_d = sub_p_q ? ($signed({p0_q[2*DW-1], p0_q}) - $signed({p1_q[2*DW-1], p1_q}))
                      : ($signed({p0_q[2*DW-1], p0_q}) + $signed({p1_q[2*DW-1], p1_q}));
        z_full_d = s_q;

        // A new event wins over a simultaneous clear.
        ovf_d      = (sat_clamp && vld_pipe_q[PS-2]) || (ovf_q && !clr_flags);
        pair_err_d = viol || (pair_err_q && !clr_flags);
    end

    // Pipeline and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_vld_q    <= 1'b0;
            s1_iq_q     <= 1'b0;
            conj_pair_q <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            a0_q        <= '0;
            b0_q        <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            sub_q       <= 1'b0;
            sub_p_q     <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            s_q         <= '0;
            z_full_q    <= '0;
            vld_pipe_q  <= '0;
            iq_pipe_q   <= '0;
            ovf_q       <= 1'b0;
            pair_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_vld_q    <= s1_vld_d;
            s1_iq_q     <= s1_iq_d;
            conj_pair_q <= conj_pair_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            sub_q       <= sub_d;
            sub_p_q     <= sub_p_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            s_q         <= s_d;
            z_full_q    <= z_full_d;
            vld_pipe_q  <= vld_pipe_d;
            iq_pipe_q   <= iq_pipe_d;
            ovf_q       <= ovf_d;
            pair_err_q  <= pair_err_d;
        end
    end

    iq_sat_shift #(.IW(2*DW+1), .DW(DW), .SHIFT(SHIFT)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .s_in  (s_q),
        .clamp (sat_clamp),
        .z     (z)
    );

    assign z_full   = z_full_q;
    assign iq_out   = iq_pipe_q[PS-1];
    assign gate_out = vld_pipe_q[PS-1];
    assign ovf      = ovf_q;
    assign pair_err = pair_err_q;

endmodule

// File: tb/tb_complex_mul_iq.sv
// tb_complex_mul_iq: directed vectors with a scoreboard queue of expected
// outputs (value and arrival cycle) and a negedge monitor that pops on gate_out.
module tb_complex_mul_iq;

    localparam int DW    = 18;
    localparam int SHIFT = 17;

    logic clk = 1'b0;
    logic rst_n, gate_in, iq, conj, clr_flags;
    logic signed [DW-1:0] x, y, z;
    logic signed [2*DW:0] z_full;
    logic iq_out, gate_out, ovf, pair_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int k;

    typedef struct {
        int          id;
        int          cyc;
        logic [63:0] z;
        logic [63:0] zf;
        logic        iq;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

`ifdef COMPLEX_MUL_ROUND_EN
    localparam longint RP = 1;
    localparam longint RN = 0;
`else
    localparam longint RP = 0;
    localparam longint RN = -1;
`endif

    complex_mul_iq #(.DW(DW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .gate_in(gate_in), .iq(iq), .conj(conj),
        .x(x), .y(y), .clr_flags(clr_flags), .z(z), .z_full(z_full),
        .iq_out(iq_out), .gate_out(gate_out), .ovf(ovf), .pair_err(pair_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every gate_out must match the oldest expectation.
    always @(negedge clk) begin
        if (gate_out === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gate_out: got z %0d at cyc %0d expected no output", z, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("v%0d_cycle", mon_e.id), cyc, mon_e.cyc);
                chk($sformatf("v%0d_z", mon_e.id), z, mon_e.z);
                chk($sformatf("v%0d_zfull", mon_e.id), z_full, mon_e.zf);
                chk($sformatf("v%0d_iq", mon_e.id), iq_out, mon_e.iq);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic i, input logic c,
                         input longint xv, input longint yv);
        gate_in = g; iq = i; conj = c;
        x = DW'(xv); y = DW'(yv);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic push(input int id, input int c, input longint zv,
                        input longint fv, input logic iv);
        exp_t e;
        e.id = id; e.cyc = c; e.z = zv; e.zf = fv; e.iq = iv;
        sbq.push_back(e);
    endtask

    // I sample (xr,yr,conj) then Q sample (xi,yi) on the next cycle.
    task automatic send_pair(input int id, input longint xr, input longint xi,
                             input longint yr, input longint yi, input logic cj,
                             input longint zr, input longint zi,
                             input longint fr, input longint fi);
        push(id, cyc + 5, zr, fr, 1'b1);
        push(id, cyc + 6, zi, fi, 1'b0);
        drive(1, 1, cj, xr, yr);
        drive(1, 0, 0, xi, yi);
    endtask

    initial begin
        rst_n = 1'b0; clr_flags = 1'b0;
        gate_in = 1'b0; iq = 1'b0; conj = 1'b0; x = '0; y = '0;
        step(); step();
        chk("rst_z", z, 0);
        chk("rst_zfull", z_full, 0);
        chk("rst_iq_out", iq_out, 0);
        chk("rst_gate_out", gate_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_pair_err", pair_err, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic product, then back-to-back conjugate-mode pairs.
        send_pair(1, 65536, 0, 65536, 65536, 0, 32768, 32768, 64'sd4294967296, 64'sd4294967296);
        send_pair(2, 0, 65536, 0, 65536, 0, -32768, 0, -64'sd4294967296, 0);
        send_pair(3, 0, 65536, 0, 65536, 1, 32768, 0, 64'sd4294967296, 0);
        idle(8);

        // Full-scale saturation: ovf only with the Q output, then sticky.
        k = cyc;
        send_pair(4, -131072, -131072, -131072, -131072, 0, 0, 131071, 0, 64'sd34359738368);
        while (cyc < k + 5) idle(1);
        chk("ovf_before_q", ovf, 0);
        idle(1);
        chk("ovf_on_q", ovf, 1);
        idle(3);
        chk("ovf_sticky", ovf, 1);
        clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Rounding versus floor.
        send_pair(5, 1, 0, 65536, 0, 0, RP, 0, 65536, 0);
        send_pair(6, -1, 0, 65536, 0, 0, RN, 0, -65536, 0);
        idle(8);

        // Framing: I, I, Q with gate held high.
        chk("perr_before", pair_err, 0);
        k = cyc;
        drive(1, 1, 0, 1000, 2000);
        chk("perr_t1", pair_err, 0);
        push(7, cyc + 5, 16384, 64'sd2147483648, 1'b1);
        push(7, cyc + 6, 32768, 64'sd4294967296, 1'b0);
        drive(1, 1, 0, 32768, 65536);
        chk("perr_orphan_i_t2", pair_err, 1);
        drive(1, 0, 0, 65536, 0);
        idle(8);
        chk("perr_sticky", pair_err, 1);
        clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
        chk("perr_cleared", pair_err, 0);

        // Orphan Q together with clr_flags: the new event wins.
        clr_flags = 1'b1;
        drive(1, 0, 0, 5, 5);
        clr_flags = 1'b0;
        chk("perr_set_beats_clr", pair_err, 1);

        // Another saturating pair so ovf is set going into reset.
        send_pair(8, -131072, -131072, -131072, -131072, 0, 0, 131071, 0, 64'sd34359738368);
        idle(8);

        // Reset between I and Q: everything clears, trailing Q is an orphan.
        drive(1, 1, 0, -131072, -131072);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mid_rst_z", z, 0);
        chk("mid_rst_zfull", z_full, 0);
        chk("mid_rst_iq_out", iq_out, 0);
        chk("mid_rst_gate_out", gate_out, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_pair_err", pair_err, 0);
        drive(1, 0, 0, -131072, -131072);
        chk("perr_q_after_rst", pair_err, 1);
        idle(10);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs still pending expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
